// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one instruction
// memory request in flight, and fills the IF/ID register. A one-entry skid
// buffer catches a response that lands while decode is stalled. A redirect
// flushes everything and retargets the PC.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        misaligned
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // REQ: may issue; WAIT: live request in flight; KILL: flushed request in flight
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        misaligned_q, misaligned_d;

  logic        handshake_s;
  logic        deliver_s;

  // A full skid buffer blocks new requests, so it can never be overwritten.
  assign imem_req_valid = (state_q == ST_REQ) && !buf_valid_q && !rst;
  assign imem_req_addr  = pc_q;
  assign handshake_s    = imem_req_valid && imem_req_ready;

  assign pc          = pc_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_inst_q;
  assign misaligned  = misaligned_q;

  // Next-state: request FSM, PC advance, IF/ID and skid buffer steering, redirect flush
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_inst_d    = buf_inst_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    misaligned_d  = misaligned_q;
    deliver_s     = 1'b0;

    // Normal request/response sequencing; redirect below may override it.
    case (state_q)
      ST_REQ: begin
        if (handshake_s) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
        end else begin
          state_d  = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          deliver_s = 1'b1;
          state_d   = ST_REQ;
        end else begin
          state_d   = ST_WAIT;
        end
      end
      ST_KILL: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_KILL;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    if (redirect) begin
      // Redirect beats stall: retarget, drop all fetched work, and
      // poison any request that is (or is about to be) in flight.
      pc_d          = {npc[31:2], 2'b00};
      if_id_valid_d = 1'b0;
      buf_valid_d   = 1'b0;
      if (npc[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end else begin
        misaligned_d = misaligned_q;
      end
      case (state_q)
        ST_REQ: begin
          if (handshake_s) begin
            state_d = ST_KILL;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT, ST_KILL: begin
          if (imem_rsp_valid) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_KILL;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end else if (!stall) begin
      // Decode advances: drain the buffer first, else take the fresh word.
      if (buf_valid_q) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = buf_pc_q;
        if_id_inst_d  = buf_inst_q;
        if (deliver_s) begin
          buf_valid_d = 1'b1;
          buf_pc_d    = req_pc_q;
          buf_inst_d  = imem_rsp_data;
        end else begin
          buf_valid_d = 1'b0;
        end
      end else if (deliver_s) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = req_pc_q;
        if_id_inst_d  = imem_rsp_data;
      end else begin
        if_id_valid_d = 1'b0;
      end
    end else begin
      // Decode stalled: IF/ID holds unless it is empty; otherwise park in buffer.
      if (deliver_s) begin
        if (!if_id_valid_q && !buf_valid_q) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = req_pc_q;
          if_id_inst_d  = imem_rsp_data;
        end else begin
          buf_valid_d = 1'b1;
          buf_pc_d    = req_pc_q;
          buf_inst_d  = imem_rsp_data;
        end
      end else begin
        buf_valid_d = buf_valid_q;
      end
    end
  end

  // State registers with asynchronous reset; reset abandons any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'h0000_0000;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= 32'h0000_0000;
      buf_inst_q    <= NOP_INST;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_inst_q  <= NOP_INST;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      buf_valid_q   <= buf_valid_d;
      buf_pc_q      <= buf_pc_d;
      buf_inst_q    <= buf_inst_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      misaligned_q  <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model that treats
// IF/ID plus the skid buffer as a two-deep queue.
module tb_if_stage;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        redirect, stall, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_req_valid, if_id_valid, misaligned;
  logic [31:0] imem_req_addr, pc, if_id_pc, if_id_inst;

  logic        r2_req_valid, r2_if_id_valid, r2_misaligned;
  logic [31:0] r2_req_addr, r2_pc, r2_if_id_pc, r2_if_id_inst;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .npc(npc), .redirect(redirect), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc(pc), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .misaligned(misaligned)
  );

  // Second instance only to observe the PC wrap from the top of the address space.
  if_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .npc(npc), .redirect(redirect), .stall(stall),
    .imem_req_valid(r2_req_valid), .imem_req_addr(r2_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc(r2_pc), .if_id_valid(r2_if_id_valid),
    .if_id_pc(r2_if_id_pc), .if_id_inst(r2_if_id_inst), .misaligned(r2_misaligned)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_req_pc;
  bit          m_out, m_stale, m_mis;
  logic [63:0] q[$];

  // memory responder state
  bit          mem_pend;
  int          mem_cnt;
  int          lat;
  logic [31:0] mem_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_req_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_mis = 1'b0;
    q.delete();
    mem_pend = 1'b0; mem_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_req_addr"}, imem_req_addr, RST_PC);
    check({tag, "_ifid_valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, "_ifid_pc"}, if_id_pc, 32'h0);
    check({tag, "_ifid_inst"}, if_id_inst, 32'h0000_0013);
    check({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
  endtask

  // One clock cycle: starts just after a falling edge with inputs already set.
  task automatic tick();
    bit          exp_rv, fire, rsp, has_new, dut_fire;
    logic [31:0] dut_addr;
    logic [63:0] entry;
    imem_rsp_valid = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(mem_addr);
        mem_pend       = 1'b0;
      end
    end
    #1;
    exp_rv = !m_out && (q.size() < 2);
    check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    check("req_addr", imem_req_addr, m_pc);
    dut_fire = imem_req_valid && imem_req_ready;
    dut_addr = imem_req_addr;
    fire = exp_rv && imem_req_ready;
    rsp  = m_out && imem_rsp_valid;
    if (redirect) begin
      q.delete();
      if (fire) begin
        m_out = 1'b1; m_stale = 1'b1;
      end else if (rsp) begin
        m_out = 1'b0;
      end else if (m_out) begin
        m_stale = 1'b1;
      end
      m_pc = {npc[31:2], 2'b00};
      if (npc[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      has_new = rsp && !m_stale;
      entry   = {m_req_pc, imem_rsp_data};
      if (!stall) begin
        if (q.size() == 2) begin
          void'(q.pop_front());
          if (has_new) q.push_back(entry);
        end else begin
          q.delete();
          if (has_new) q.push_back(entry);
        end
      end else if (has_new) begin
        q.push_back(entry);
      end
      if (rsp) m_out = 1'b0;
      if (fire) begin
        m_out = 1'b1; m_stale = 1'b0; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    if (dut_fire) begin
      mem_pend = 1'b1; mem_cnt = lat; mem_addr = dut_addr;
    end
    #1;
    check("pc", pc, m_pc);
    check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    check("ifid_valid", {31'd0, if_id_valid}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      entry = q[0];
      check("ifid_pc", if_id_pc, entry[63:32]);
      check("ifid_inst", if_id_inst, entry[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit rd, input logic [31:0] n, input bit st, input bit rdy);
    redirect = rd; npc = n; stall = st; imem_req_ready = rdy;
    tick();
  endtask

  initial begin
    rst = 1'b1; npc = 32'h0; redirect = 1'b0; stall = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    lat = 1;
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    check("wrap_reset_pc", r2_pc, WRAP_PC);
    check("wrap_reset_ifid", {r2_if_id_valid, r2_misaligned, r2_req_valid, 29'd0}
          | r2_if_id_pc | (r2_if_id_inst ^ 32'h0000_0013), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming fetch with zero-wait memory; wrap instance checked alongside.
    check("wrap_first_addr", r2_req_addr, WRAP_PC);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);                 // req 0x0
    cyc(1'b0, 32'h0, 1'b0, 1'b1);                 // rsp w0
    check("wrap_second_valid", {31'd0, r2_req_valid}, 32'd1);
    check("wrap_second_addr", r2_req_addr, 32'h0000_0000);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);                 // IF/ID (0,w0), req 0x4
    cyc(1'b0, 32'h0, 1'b0, 1'b1);                 // rsp w1
    // Stall for 6 cycles: IF/ID holds (4,w1), buffer takes (8,w2)
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    check("stall_buf_hold_ifid_pc", if_id_pc, 32'h0000_0004);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);                 // buffer -> IF/ID
    check("stall_release_pc", if_id_pc, 32'h0000_0008);
    lat = 3;
    cyc(1'b0, 32'h0, 1'b0, 1'b1);                 // req 0xC, slow response
    check("after_stall_req", mem_addr, 32'h0000_000C);
    // Redirect in WAIT; stale response arrives later and is discarded.
    cyc(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    check("redir_addr", imem_req_addr, 32'h0000_0100);
    lat = 1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    // Redirect coinciding with a response.
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    // Fill the buffer under stall, then redirect during the stall.
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 32'h0000_0300, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    // Misaligned redirect target.
    cyc(1'b1, 32'h0000_0103, 1'b0, 1'b0);
    check("mis_addr", imem_req_addr, 32'h0000_0100);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("mis_sticky", {31'd0, misaligned}, 32'd1);

    // Asynchronous reset in the middle of a WAIT.
    lat = 4;
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat = 1;
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("post_rst_req", mem_addr, RST_PC);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] n;
      lat = int'($urandom_range(1, 4));
      n = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
      cyc(($urandom_range(0, 99) < 8), n, ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 70));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck run still reports.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
